// File: rtl/reg_bank_pkg.sv
// Shared op encoding for the register bank and its per-register cells.
package reg_bank_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_CLEAR = 3'b010,
    OP_INC   = 3'b011,
    OP_DEC   = 3'b100,
    OP_SHL   = 3'b101,
    OP_SHR   = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;
endpackage

// File: rtl/reg_cell.sv
// One register of the bank plus its carry/borrow/shift-out flag.
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter bit              SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             cout
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic all_ones, all_zero;
  assign all_ones = &q;
  assign all_zero = ~|q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      cout <= 1'b0;
    end else begin
      case (op)
        OP_LOAD:  begin q <= din; cout <= 1'b0; end
        OP_CLEAR: begin q <= '0;  cout <= 1'b0; end
        OP_INC: begin
          // Saturating mode pins at all-ones but still flags the overflow.
          if (all_ones) begin
            q    <= SATURATE ? q : '0;
            cout <= 1'b1;
          end else begin
            q    <= q + ONE;
            cout <= 1'b0;
          end
        end
        OP_DEC: begin
          if (all_zero) begin
            q    <= SATURATE ? q : '1;
            cout <= 1'b1;
          end else begin
            q    <= q - ONE;
            cout <= 1'b0;
          end
        end
        OP_SHL: begin q <= {q[WIDTH-2:0], 1'b0}; cout <= q[WIDTH-1]; end
        OP_SHR: begin q <= {1'b0, q[WIDTH-1:1]}; cout <= q[0]; end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/reg_bank.sv
// Bank of independently-operated registers with a read mux and zero flags.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 8,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OP_W*NUM_REGS-1:0]  op,
  input  logic [WIDTH-1:0]          din,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          bus,
  output logic [WIDTH*NUM_REGS-1:0] q,
  output logic [NUM_REGS-1:0]       zero,
  output logic [NUM_REGS-1:0]       cout
);
  logic [NUM_REGS-1:0][WIDTH-1:0] regs;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    reg_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE),
      .RESET_VAL(RESET_VAL)
    ) u_cell (
      .clk (clk),
      .rst_n(rst_n),
      .op  (op[OP_W*i +: OP_W]),
      .din (din),
      .q   (regs[i]),
      .cout(cout[i])
    );
    assign zero[i] = (regs[i] == '0);
  end

  assign q = regs;

  // Out-of-range selects fall through to zero.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(sel) == i) bus = regs[i];
  end
endmodule
